scariv_muldiv_issue_sched: RTL and testbench

//  Issue scheduler in front of the mul/div pipe. Holds up to ENTRY_SIZE dispatched mul/div ops.

---
 rtl/scariv_muldiv_issue_sched.sv | 219 +++++++++++++++++++++
 tb/tb_scariv_muldiv_issue_sched.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_muldiv_issue_sched.sv
// Mul/div issue scheduler: holds dispatched ops, tracks operand wakeup, issues the oldest ready op.
// Optional SCARIV_MULDIV_SCHED_PERF_EN adds issue and stall performance counters.
module scariv_muldiv_issue_sched #(
   parameter int ENTRY_SIZE = 8,
   parameter int OP_W       = 6,
   parameter int RNID_W     = 7,
   parameter int BR_MASK_W  = 4,
   parameter int TAG_W      = 6
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_disp_valid,
   output logic                         o_disp_ready,
   input  logic [OP_W-1:0]              i_disp_op,
   input  logic                         i_disp_is_div,
   input  logic [TAG_W-1:0]             i_disp_tag,
   input  logic [BR_MASK_W-1:0]         i_disp_br_mask,
   input  logic [RNID_W-1:0]            i_disp_rs1_rnid,
   input  logic                         i_disp_rs1_ready,
   input  logic [RNID_W-1:0]            i_disp_rs2_rnid,
   input  logic                         i_disp_rs2_ready,
   input  logic                         i_wake_valid,
   input  logic [RNID_W-1:0]            i_wake_rnid,
   input  logic                         i_pipe_stall,
   output logic                         o_issue_valid,
   output logic [OP_W-1:0]              o_issue_op,
   output logic [TAG_W-1:0]             o_issue_tag,
   output logic [BR_MASK_W-1:0]         o_issue_br_mask,
   output logic [ENTRY_SIZE-1:0]        o_issue_index_oh,
   input  logic                         i_div_done,
   input  logic                         i_commit_flush,
   input  logic                         i_br_update,
   input  logic [$clog2(BR_MASK_W)-1:0] i_br_tag,
   input  logic                         i_br_mispredict
`ifdef SCARIV_MULDIV_SCHED_PERF_EN
   ,
   output logic [31:0]                  o_perf_issue_cnt,
   output logic [31:0]                  o_perf_stall_cnt
`endif
);

   localparam int IDX_W = $clog2(ENTRY_SIZE);

   logic [ENTRY_SIZE-1:0] valid_q, valid_d;
   logic [ENTRY_SIZE-1:0] is_div_q, is_div_d;
   logic [ENTRY_SIZE-1:0] rs1_rdy_q, rs1_rdy_d;
   logic [ENTRY_SIZE-1:0] rs2_rdy_q, rs2_rdy_d;
   logic [OP_W-1:0]       op_q [ENTRY_SIZE];
   logic [OP_W-1:0]       op_d [ENTRY_SIZE];
   logic [TAG_W-1:0]      tag_q [ENTRY_SIZE];
   logic [TAG_W-1:0]      tag_d [ENTRY_SIZE];
   logic [BR_MASK_W-1:0]  br_mask_q [ENTRY_SIZE];
   logic [BR_MASK_W-1:0]  br_mask_d [ENTRY_SIZE];
   logic [RNID_W-1:0]     rs1_rnid_q [ENTRY_SIZE];
   logic [RNID_W-1:0]     rs1_rnid_d [ENTRY_SIZE];
   logic [RNID_W-1:0]     rs2_rnid_q [ENTRY_SIZE];
   logic [RNID_W-1:0]     rs2_rnid_d [ENTRY_SIZE];
   // age_q[i][j] = 1: entry j is older than entry i
   logic [ENTRY_SIZE-1:0] age_q [ENTRY_SIZE];
   logic [ENTRY_SIZE-1:0] age_d [ENTRY_SIZE];
   logic                  div_busy_q, div_busy_d;
   logic [BR_MASK_W-1:0]  div_mask_q, div_mask_d;

   logic [ENTRY_SIZE-1:0] kill;
   logic [ENTRY_SIZE-1:0] eligible;
   logic [ENTRY_SIZE-1:0] sel_oh;
   logic [BR_MASK_W-1:0]  br_clr;
   logic [IDX_W-1:0]      free_idx;
   logic                  disp_fire;
   logic                  disp_kill;
   logic                  issue_fire;
   logic                  div_issue;
   logic                  mispred;
   logic [OP_W-1:0]       sel_op;
   logic [TAG_W-1:0]      sel_tag;
   logic [BR_MASK_W-1:0]  sel_br_mask;

   assign o_disp_ready = ~&valid_q;
   assign disp_fire    = i_disp_valid & o_disp_ready;
   assign mispred      = i_br_update & i_br_mispredict;

   always_comb begin
      br_clr = '0;
      if (i_br_update && !i_br_mispredict) begin
         br_clr[i_br_tag] = 1'b1;
      end
      free_idx = '0;
      for (int i = ENTRY_SIZE - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         kill[i]     = i_commit_flush | (mispred & br_mask_q[i][i_br_tag]);
         eligible[i] = valid_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i] & ~kill[i] &
                       (~is_div_q[i] | ~div_busy_q);
      end
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         sel_oh[i] = eligible[i] & ~|(age_q[i] & eligible);
      end
      sel_op      = '0;
      sel_tag     = '0;
      sel_br_mask = '0;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         if (sel_oh[i]) begin
            sel_op      = sel_op | op_q[i];
            sel_tag     = sel_tag | tag_q[i];
            sel_br_mask = sel_br_mask | br_mask_q[i];
         end
      end
      issue_fire = |eligible & ~i_pipe_stall & ~i_commit_flush;
      div_issue  = issue_fire & |(sel_oh & is_div_q);
   end

   assign o_issue_valid    = issue_fire;
   assign o_issue_op       = issue_fire ? sel_op : '0;
   assign o_issue_tag      = issue_fire ? sel_tag : '0;
   assign o_issue_br_mask  = issue_fire ? (sel_br_mask & ~br_clr) : '0;
   assign o_issue_index_oh = issue_fire ? sel_oh : '0;
   assign disp_kill        = i_commit_flush | (mispred & i_disp_br_mask[i_br_tag]);

   always_comb begin
      is_div_d   = is_div_q;
      op_d       = op_q;
      tag_d      = tag_q;
      rs1_rnid_d = rs1_rnid_q;
      rs2_rnid_d = rs2_rnid_q;
      age_d      = age_q;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         valid_d[i]   = valid_q[i] & ~kill[i] & ~(issue_fire & sel_oh[i]);
         rs1_rdy_d[i] = rs1_rdy_q[i] | (i_wake_valid & (rs1_rnid_q[i] == i_wake_rnid));
         rs2_rdy_d[i] = rs2_rdy_q[i] | (i_wake_valid & (rs2_rnid_q[i] == i_wake_rnid));
         br_mask_d[i] = br_mask_q[i] & ~br_clr;
      end
      if (disp_fire) begin
         valid_d[free_idx]    = ~disp_kill;
         is_div_d[free_idx]   = i_disp_is_div;
         op_d[free_idx]       = i_disp_op;
         tag_d[free_idx]      = i_disp_tag;
         br_mask_d[free_idx]  = i_disp_br_mask & ~br_clr;
         rs1_rnid_d[free_idx] = i_disp_rs1_rnid;
         rs2_rnid_d[free_idx] = i_disp_rs2_rnid;
         rs1_rdy_d[free_idx]  = i_disp_rs1_ready |
                                (i_wake_valid & (i_disp_rs1_rnid == i_wake_rnid));
         rs2_rdy_d[free_idx]  = i_disp_rs2_ready |
                                (i_wake_valid & (i_disp_rs2_rnid == i_wake_rnid));
         // stale column bits from a previous occupant of this slot are cleared here
         for (int r = 0; r < ENTRY_SIZE; r++) begin
            age_d[r][free_idx] = 1'b0;
         end
         age_d[free_idx] = valid_q;
      end

      div_mask_d = div_mask_q & ~br_clr;
      div_busy_d = div_busy_q;
      if (i_commit_flush) begin
         div_busy_d = 1'b0;
      end else if (div_issue) begin
         div_busy_d = 1'b1;
         div_mask_d = sel_br_mask & ~br_clr;
      end else if (i_div_done || (mispred && div_mask_q[i_br_tag])) begin
         div_busy_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q    <= '0;
         is_div_q   <= '0;
         rs1_rdy_q  <= '0;
         rs2_rdy_q  <= '0;
         div_busy_q <= 1'b0;
         div_mask_q <= '0;
         for (int i = 0; i < ENTRY_SIZE; i++) begin
            op_q[i]       <= '0;
            tag_q[i]      <= '0;
            br_mask_q[i]  <= '0;
            rs1_rnid_q[i] <= '0;
            rs2_rnid_q[i] <= '0;
            age_q[i]      <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         is_div_q   <= is_div_d;
         rs1_rdy_q  <= rs1_rdy_d;
         rs2_rdy_q  <= rs2_rdy_d;
         div_busy_q <= div_busy_d;
         div_mask_q <= div_mask_d;
         op_q       <= op_d;
         tag_q      <= tag_d;
         br_mask_q  <= br_mask_d;
         rs1_rnid_q <= rs1_rnid_d;
         rs2_rnid_q <= rs2_rnid_d;
         age_q      <= age_d;
      end
   end

`ifdef SCARIV_MULDIV_SCHED_PERF_EN
   logic [31:0] perf_issue_q, perf_stall_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (issue_fire) begin
            perf_issue_q <= perf_issue_q + 32'd1;
         end
         if (|eligible && i_pipe_stall) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign o_perf_issue_cnt = perf_issue_q;
   assign o_perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_scariv_muldiv_issue_sched.sv
// Directed bench for scariv_muldiv_issue_sched: one task per scenario with inline checks.
module tb_scariv_muldiv_issue_sched;

   logic       clk;
   logic       rst;
   logic       disp_valid;
   logic       disp_ready;
   logic [5:0] disp_op;
   logic       disp_is_div;
   logic [5:0] disp_tag;
   logic [3:0] disp_br_mask;
   logic [6:0] disp_rs1_rnid;
   logic       disp_rs1_ready;
   logic [6:0] disp_rs2_rnid;
   logic       disp_rs2_ready;
   logic       wake_valid;
   logic [6:0] wake_rnid;
   logic       pipe_stall;
   logic       issue_valid;
   logic [5:0] issue_op;
   logic [5:0] issue_tag;
   logic [3:0] issue_br_mask;
   logic [7:0] issue_index_oh;
   logic       div_done;
   logic       commit_flush;
   logic       br_update;
   logic [1:0] br_tag;
   logic       br_mispredict;
`ifdef SCARIV_MULDIV_SCHED_PERF_EN
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   scariv_muldiv_issue_sched dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_disp_valid     (disp_valid),
      .o_disp_ready     (disp_ready),
      .i_disp_op        (disp_op),
      .i_disp_is_div    (disp_is_div),
      .i_disp_tag       (disp_tag),
      .i_disp_br_mask   (disp_br_mask),
      .i_disp_rs1_rnid  (disp_rs1_rnid),
      .i_disp_rs1_ready (disp_rs1_ready),
      .i_disp_rs2_rnid  (disp_rs2_rnid),
      .i_disp_rs2_ready (disp_rs2_ready),
      .i_wake_valid     (wake_valid),
      .i_wake_rnid      (wake_rnid),
      .i_pipe_stall     (pipe_stall),
      .o_issue_valid    (issue_valid),
      .o_issue_op       (issue_op),
      .o_issue_tag      (issue_tag),
      .o_issue_br_mask  (issue_br_mask),
      .o_issue_index_oh (issue_index_oh),
      .i_div_done       (div_done),
      .i_commit_flush   (commit_flush),
      .i_br_update      (br_update),
      .i_br_tag         (br_tag),
      .i_br_mispredict  (br_mispredict)
`ifdef SCARIV_MULDIV_SCHED_PERF_EN
      ,
      .o_perf_issue_cnt (perf_issue_cnt),
      .o_perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid     = 1'b0;
      disp_op        = '0;
      disp_is_div    = 1'b0;
      disp_tag       = '0;
      disp_br_mask   = '0;
      disp_rs1_rnid  = '0;
      disp_rs1_ready = 1'b0;
      disp_rs2_rnid  = '0;
      disp_rs2_ready = 1'b0;
      wake_valid     = 1'b0;
      wake_rnid      = '0;
      div_done       = 1'b0;
      commit_flush   = 1'b0;
      br_update      = 1'b0;
      br_tag         = '0;
      br_mispredict  = 1'b0;
   endtask

   task automatic drive_disp(input logic [5:0] tag, input logic is_div, input logic [3:0] brm,
                             input logic rs1_rdy, input logic [6:0] rs1_id);
      disp_valid     = 1'b1;
      disp_op        = is_div ? 6'h21 : 6'h11;
      disp_is_div    = is_div;
      disp_tag       = tag;
      disp_br_mask   = brm;
      disp_rs1_rnid  = rs1_id;
      disp_rs1_ready = rs1_rdy;
      disp_rs2_rnid  = 7'd99;
      disp_rs2_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      pipe_stall = 1'b0;
      step();
      n_checks++;
      if (disp_ready !== 1'b1 || issue_valid !== 1'b0 || issue_index_oh !== 8'h00 ||
          issue_tag !== 6'h00 || issue_op !== 6'h00 || issue_br_mask !== 4'h0)
         $display("FAIL reset_values: ready=%b valid=%b oh=%h tag=%h op=%h brm=%h required 1 0 00 00 00 0",
                  disp_ready, issue_valid, issue_index_oh, issue_tag, issue_op, issue_br_mask);
      else n_pass++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic_issue();
      drive_disp(6'd5, 1'b0, 4'h0, 1'b1, 7'd1);
      #1;
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL basic_no_same_cycle: valid=%b required 0", issue_valid);
      else n_pass++;
      step();
      idle();
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd5 || issue_index_oh !== 8'h01 || issue_op !== 6'h11)
         $display("FAIL basic_issue: valid=%b tag=%0d oh=%h op=%h required 1 5 01 11",
                  issue_valid, issue_tag, issue_index_oh, issue_op);
      else n_pass++;
      step();
   endtask

   task automatic test_stall();
      pipe_stall = 1'b1;
      drive_disp(6'd1, 1'b0, 4'h0, 1'b1, 7'd1);
      step();
      drive_disp(6'd2, 1'b0, 4'h0, 1'b1, 7'd1);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (issue_valid !== 1'b0)
            $display("FAIL stall_hold_%0d: valid=%b required 0", c, issue_valid);
         else n_pass++;
         step();
         idle();
      end
      pipe_stall = 1'b0;
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd1 || issue_index_oh !== 8'h01)
         $display("FAIL stall_release_a: valid=%b tag=%0d oh=%h required 1 1 01",
                  issue_valid, issue_tag, issue_index_oh);
      else n_pass++;
      step();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd2 || issue_index_oh !== 8'h02)
         $display("FAIL stall_release_b: valid=%b tag=%0d oh=%h required 1 2 02",
                  issue_valid, issue_tag, issue_index_oh);
      else n_pass++;
      step();
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL stall_drained: valid=%b required 0", issue_valid);
      else n_pass++;
   endtask

   task automatic test_div_serial();
      drive_disp(6'd3, 1'b1, 4'h0, 1'b1, 7'd1);
      step();
      drive_disp(6'd4, 1'b1, 4'h0, 1'b1, 7'd1);
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd3 || issue_index_oh !== 8'h01 || issue_op !== 6'h21)
         $display("FAIL div_first: valid=%b tag=%0d oh=%h op=%h required 1 3 01 21",
                  issue_valid, issue_tag, issue_index_oh, issue_op);
      else n_pass++;
      step();
      idle();
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (issue_valid !== 1'b0)
            $display("FAIL div_held_%0d: valid=%b required 0", c, issue_valid);
         else n_pass++;
         step();
      end
      div_done = 1'b1;
      #1;
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL div_done_cycle: valid=%b required 0", issue_valid);
      else n_pass++;
      step();
      div_done = 1'b0;
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd4 || issue_index_oh !== 8'h02)
         $display("FAIL div_second: valid=%b tag=%0d oh=%h required 1 4 02",
                  issue_valid, issue_tag, issue_index_oh);
      else n_pass++;
      step();
      div_done = 1'b1;
      step();
      div_done = 1'b0;
   endtask

   task automatic test_full();
      for (int k = 0; k < 8; k++) begin
         drive_disp(6'(16 + k), 1'b0, 4'h0, 1'b0, 7'd10);
         step();
      end
      idle();
      #1;
      n_checks++;
      if (disp_ready !== 1'b0 || issue_valid !== 1'b0)
         $display("FAIL full_ready: ready=%b valid=%b required 0 0", disp_ready, issue_valid);
      else n_pass++;
      drive_disp(6'd40, 1'b0, 4'h0, 1'b1, 7'd1);
      step();
      idle();
      wake_valid = 1'b1;
      wake_rnid  = 7'd10;
      step();
      idle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd16 || issue_index_oh !== 8'h01 || disp_ready !== 1'b0)
         $display("FAIL full_wake_oldest: valid=%b tag=%0d oh=%h ready=%b required 1 16 01 0",
                  issue_valid, issue_tag, issue_index_oh, disp_ready);
      else n_pass++;
      step();
      n_checks++;
      if (disp_ready !== 1'b1)
         $display("FAIL full_ready_rise: ready=%b required 1", disp_ready);
      else n_pass++;
      for (int k = 1; k < 8; k++) begin
         n_checks++;
         if (issue_valid !== 1'b1 || issue_tag !== 6'(16 + k) || issue_index_oh !== (8'h01 << k))
            $display("FAIL full_drain_%0d: valid=%b tag=%0d oh=%h required 1 %0d %h",
                     k, issue_valid, issue_tag, issue_index_oh, 16 + k, 8'h01 << k);
         else n_pass++;
         step();
      end
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL full_dropped: valid=%b tag=%0d required no issue", issue_valid, issue_tag);
      else n_pass++;
   endtask

   task automatic test_branch();
      drive_disp(6'd30, 1'b0, 4'b0010, 1'b0, 7'd20);
      step();
      drive_disp(6'd31, 1'b0, 4'b0100, 1'b0, 7'd20);
      step();
      idle();
      br_update = 1'b1; br_tag = 2'd1; br_mispredict = 1'b1;
      step();
      br_tag = 2'd2; br_mispredict = 1'b0;
      step();
      idle();
      wake_valid = 1'b1;
      wake_rnid  = 7'd20;
      step();
      idle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd31 || issue_index_oh !== 8'h02 || issue_br_mask !== 4'h0)
         $display("FAIL br_survivor: valid=%b tag=%0d oh=%h brm=%b required 1 31 02 0000",
                  issue_valid, issue_tag, issue_index_oh, issue_br_mask);
      else n_pass++;
      step();
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL br_killed: valid=%b tag=%0d required no issue", issue_valid, issue_tag);
      else n_pass++;
      drive_disp(6'd32, 1'b0, 4'b0001, 1'b1, 7'd1);
      step();
      idle();
      br_update = 1'b1; br_tag = 2'd0; br_mispredict = 1'b0;
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd32 || issue_br_mask !== 4'h0)
         $display("FAIL br_issue_mask_clear: valid=%b tag=%0d brm=%b required 1 32 0000",
                  issue_valid, issue_tag, issue_br_mask);
      else n_pass++;
      step();
      idle();
      drive_disp(6'd33, 1'b0, 4'b1000, 1'b1, 7'd1);
      step();
      idle();
      br_update = 1'b1; br_tag = 2'd3; br_mispredict = 1'b1;
      #1;
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL br_kill_same_cycle: valid=%b required 0", issue_valid);
      else n_pass++;
      step();
      idle();
      #1;
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL br_kill_gone: valid=%b tag=%0d required no issue", issue_valid, issue_tag);
      else n_pass++;
   endtask

   task automatic test_flush();
      drive_disp(6'd50, 1'b1, 4'h0, 1'b1, 7'd1);
      step();
      idle();
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd50)
         $display("FAIL flush_div_issue: valid=%b tag=%0d required 1 50", issue_valid, issue_tag);
      else n_pass++;
      step();
      pipe_stall = 1'b1;
      drive_disp(6'd51, 1'b0, 4'h0, 1'b0, 7'd30);
      step();
      drive_disp(6'd52, 1'b0, 4'h0, 1'b0, 7'd30);
      step();
      drive_disp(6'd53, 1'b0, 4'h0, 1'b1, 7'd1);
      step();
      idle();
      pipe_stall   = 1'b0;
      commit_flush = 1'b1;
      drive_disp(6'd54, 1'b0, 4'h0, 1'b1, 7'd1);
      #1;
      n_checks++;
      if (issue_valid !== 1'b0 || issue_index_oh !== 8'h00)
         $display("FAIL flush_suppress: valid=%b oh=%h required 0 00", issue_valid, issue_index_oh);
      else n_pass++;
      step();
      idle();
      #1;
      n_checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1)
         $display("FAIL flush_cleared: valid=%b tag=%0d ready=%b required 0 - 1",
                  issue_valid, issue_tag, disp_ready);
      else n_pass++;
      wake_valid = 1'b1;
      wake_rnid  = 7'd30;
      step();
      idle();
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL flush_no_wake_issue: valid=%b tag=%0d required 0", issue_valid, issue_tag);
      else n_pass++;
      drive_disp(6'd56, 1'b1, 4'h0, 1'b1, 7'd1);
      step();
      idle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 6'd56)
         $display("FAIL flush_div_busy_clear: valid=%b tag=%0d required 1 56", issue_valid, issue_tag);
      else n_pass++;
      step();
      div_done = 1'b1;
      step();
      idle();
      drive_disp(6'd57, 1'b0, 4'h0, 1'b1, 7'd1);
      step();
      idle();
      commit_flush = 1'b1;
      rst          = 1'b1;
      #1;
      n_checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1 || issue_index_oh !== 8'h00 || issue_tag !== 6'h00)
         $display("FAIL flush_reset: valid=%b ready=%b oh=%h tag=%h required 0 1 00 00",
                  issue_valid, disp_ready, issue_index_oh, issue_tag);
      else n_pass++;
      step();
      rst = 1'b0;
      idle();
      step();
      n_checks++;
      if (issue_valid !== 1'b0 || disp_ready !== 1'b1)
         $display("FAIL after_reset: valid=%b ready=%b required 0 1", issue_valid, disp_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_stall();
      test_div_serial();
      test_full();
      test_branch();
      test_flush();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
